fxp32_acc_sat: RTL and testbench

FXP32_ACC_SAT -- requirements
Module: fxp32_acc_sat

---
 rtl/fxp32_acc_sat_pkg.sv | 19 +
 rtl/fxp32_cla.sv | 58 +++++
 rtl/fxp32_acc_sat.sv | 95 +++++++++
 tb/tb_fxp32_acc_sat.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fxp32_acc_sat_pkg.sv
// Shared constants and types for the saturating Q(32-FRAC).FRAC frame accumulator.
// The 32-bit word type, its sign-bit index and the saturation limits live here.
package fxp32_acc_sat_pkg;

    localparam int FXP32_W   = 32;
    localparam int FXP32_MSB = FXP32_W - 1;

    typedef logic [FXP32_MSB:0] fxp32_t;

    localparam fxp32_t FXP32_MAX = 32'h7FFF_FFFF;
    localparam fxp32_t FXP32_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fxp32_cla.sv
// 32-bit carry-lookahead adder: 4-bit groups, with each group's carry-in
// derived from the lower groups' generate/propagate terms.
module fxp32_cla
    import fxp32_acc_sat_pkg::*;
(
    input  fxp32_t a,
    input  fxp32_t b,
    input  logic   cin,
    output fxp32_t sum
);

    fxp32_t     g;
    fxp32_t     p;
    fxp32_t     c;
    logic [6:0] grp_g;
    logic [6:0] grp_p;

    assign g = a & b;
    assign p = a ^ b;

    // Only the seven lower groups feed a higher group's carry.
    always_comb begin
        logic gg;
        logic gp;
        grp_g = '0;
        grp_p = '0;
        for (int k = 0; k < 7; k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < 4; i++) begin
                gg = g[4*k+i] | (p[4*k+i] & gg);
                gp = gp & p[4*k+i];
            end
            grp_g[k] = gg;
            grp_p[k] = gp;
        end
    end

    always_comb begin
        logic gc;
        logic bc;
        c = '0;
        for (int k = 0; k < 8; k++) begin
            gc = cin;
            for (int j = 0; j < k; j++) begin
                gc = grp_g[j] | (grp_p[j] & gc);
            end
            bc = gc;
            for (int i = 0; i < 4; i++) begin
                c[4*k+i] = bc;
                bc = g[4*k+i] | (p[4*k+i] & bc);
            end
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/fxp32_acc_sat.sv
// Frame accumulator: sums signed fixed-point samples with saturation, counts them,
// and holds the frame result until the consumer takes it.
// Handshake: a transfer happens on a rising edge where valid && ready are both high;
// valid never waits on ready, and held output data stays stable until the transfer.
module fxp32_acc_sat
    import fxp32_acc_sat_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count,
    output state_t           dbg_state
);

    if (FRAC < 0 || FRAC > FXP32_W) begin : g_bad_frac
        $error("fxp32_acc_sat: FRAC out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("fxp32_acc_sat: CNT_W must be at least 1");
    end

    state_t           state_q, state_d;
    fxp32_t           acc_q, acc_d;
    fxp32_t           raw_sum, sat_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             ovf;
    logic             xfer;

    fxp32_cla u_cla (
        .a   (acc_q),
        .b   (in_data),
        .cin (1'b0),
        .sum (raw_sum)
    );

    // Overflow only when both operands share a sign the raw sum does not.
    assign ovf     = (acc_q[FXP32_MSB] == in_data[FXP32_MSB]) &&
                     (raw_sum[FXP32_MSB] != acc_q[FXP32_MSB]);
    assign sat_sum = ovf ? (acc_q[FXP32_MSB] ? FXP32_MIN : FXP32_MAX) : raw_sum;

    assign in_ready = (state_q != HOLD) && !clr;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (clr || (state_q == HOLD && out_ready)) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else if (xfer) begin
            acc_d   = sat_sum;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            sat_d   = sat_q | ovf;
            state_d = in_last ? HOLD : ACC;
        end
    end

    // Outside HOLD the outputs expose the live running values.
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc_q;
    assign out_sat   = sat_q;
    assign out_count = cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fxp32_acc_sat.sv
// Self-checking bench for fxp32_acc_sat: directed scenarios plus random frames
// compared against a wide-integer clamp model of the frame sum.
module tb_fxp32_acc_sat;
    import fxp32_acc_sat_pkg::*;

    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             clr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_sat;
    logic [CNT_W-1:0] out_count;
    state_t           dbg_state;

    int checks;
    int failures;

    logic [31:0]      frame_q[$];
    logic [31:0]      exp_q[$];
    logic [31:0]      exp_data;
    logic             exp_sat;
    logic [CNT_W-1:0] exp_cnt;

    fxp32_acc_sat #(.CNT_W(CNT_W), .FRAC(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_count (out_count),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact sum in 64 bits, clamped to the int32 range after every add.
    task automatic model_frame();
        longint s;
        int     v;
        int     n;
        s = 0;
        exp_sat = 1'b0;
        foreach (frame_q[i]) begin
            v = int'(frame_q[i]);
            s = s + longint'(v);
            if (s > 64'sd2147483647) begin
                s = 64'sd2147483647;
                exp_sat = 1'b1;
            end else if (s < -64'sd2147483648) begin
                s = -64'sd2147483648;
                exp_sat = 1'b1;
            end
        end
        exp_data = s[31:0];
        n = frame_q.size();
        exp_cnt = (n >= CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
    endtask

    // driver: presents frame_q (optionally with idle gaps) and checks the single-cycle result
    task automatic run_frame(input string name, input bit gaps);
        logic [31:0] want;
        model_frame();
        exp_q.push_back(exp_data);
        out_ready = 1'b1;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL %s in_ready sample %0d: got %b want 1", name, i, in_ready);
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s out_valid: got %b want 1", name, out_valid);
        end
        checks++;
        if (out_data !== want) begin
            failures++;
            $display("FAIL %s out_data: got %h want %h", name, out_data, want);
        end
        checks++;
        if (out_sat !== exp_sat) begin
            failures++;
            $display("FAIL %s out_sat: got %b want %b", name, out_sat, exp_sat);
        end
        checks++;
        if (out_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s out_count: got %0d want %0d", name, out_count, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_count !== '0) begin
            failures++;
            $display("FAIL %s release: got valid=%b count=%0d want valid=0 count=0",
                     name, out_valid, out_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        clr = 1'b0; out_ready = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sat !== 1'b0 ||
            out_count !== '0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset: got valid=%b data=%h sat=%b count=%0d state=%0d want all zero/IDLE",
                     out_valid, out_data, out_sat, out_count, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        frame_q = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
        run_frame("basic", 1'b0);
        frame_q = '{32'h1234_5678};
        run_frame("single", 1'b0);
    endtask

    task automatic test_saturation();
        frame_q = '{32'h7FFF_0000, 32'h0002_0000};
        run_frame("pos_sat", 1'b0);
        frame_q = '{32'hFFFF_FFFF};
        run_frame("after_sat", 1'b0);
        frame_q = '{32'h8000_0000, 32'hFFFF_FFFF};
        run_frame("neg_sat", 1'b0);
        frame_q = '{32'h7000_0000, 32'h7000_0000, 32'h9000_0000};
        run_frame("sat_sticky", 1'b0);
    endtask

    task automatic test_count_sat();
        frame_q = {};
        for (int i = 0; i < CNT_MAX + 3; i++) frame_q.push_back(32'(i + 1));
        run_frame("count_sat", 1'b0);
    endtask

    task automatic test_backpressure();
        logic bad;
        frame_q = '{32'h0001_0000, 32'h0000_0005};
        model_frame();
        out_ready = 1'b0;
        foreach (frame_q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
        end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_data ||
                out_count !== exp_cnt || out_sat !== exp_sat) begin
                bad = 1'b1;
                $display("FAIL hold cycle %0d: got ready=%b valid=%b data=%h count=%0d want 0 1 %h %0d",
                         c, in_ready, out_valid, out_data, out_count, exp_data, exp_cnt);
            end
            in_valid = 1'b1;
            in_data  = $urandom();
            in_last  = 1'($urandom_range(0, 1));
        end
        checks++;
        if (bad) failures++;
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dbg_state !== IDLE || out_data !== 32'h0 || out_count !== '0) begin
            failures++;
            $display("FAIL hold_release: got valid=%b state=%0d data=%h count=%0d want 0 IDLE 0 0",
                     out_valid, dbg_state, out_data, out_count);
        end
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0002_0000; in_last = 1'b0;
        @(negedge clk);
        in_data = 32'h0003_0000;
        @(negedge clk);
        checks++;
        if (out_data !== 32'h0005_0000 || dbg_state !== ACC) begin
            failures++;
            $display("FAIL clr_pre: got data=%h state=%0d want 00050000 ACC", out_data, dbg_state);
        end
        clr = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0100;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_ready: got %b want 0", in_ready);
        end
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_data !== 32'h0 || out_count !== '0 || out_sat !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL clr_state: got data=%h count=%0d sat=%b state=%0d want 0 0 0 IDLE",
                     out_data, out_count, out_sat, dbg_state);
        end
        frame_q = '{32'h0000_0001};
        run_frame("clr_next", 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        frame_q = '{32'h0000_0003, 32'h0000_0004}; model_frame(); exp_a = exp_data;
        frame_q = '{32'h0000_000A, 32'h0000_0014}; model_frame(); exp_b = exp_data;
        out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b1; in_data = 32'h0000_0003; in_last = 1'b0;
        @(negedge clk); in_data = 32'h0000_0004; in_last = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: got valid=%b data=%h ready=%b want 1 %h 0",
                     out_valid, out_data, in_ready, exp_a);
        end
        in_data = 32'h0000_000A; in_last = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL b2b_gap: got valid=%b ready=%b data=%h want 0 1 0",
                     out_valid, in_ready, out_data);
        end
        @(negedge clk); in_data = 32'h0000_0014; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_b || out_count !== CNT_W'(2)) begin
            failures++;
            $display("FAIL b2b_second: got valid=%b data=%h count=%0d want 1 %h 2",
                     out_valid, out_data, out_count, exp_b);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic bad;
        frame_q = '{32'h0001_0000, 32'h0001_0000};
        out_ready = 1'b0;
        foreach (frame_q[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = (i == frame_q.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL arst_hold: got valid=%b want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_count !== '0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL arst_immediate: got valid=%b data=%h count=%0d sat=%b want zeros",
                     out_valid, out_data, out_count, out_sat);
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || dbg_state !== IDLE) begin
                bad = 1'b1;
                $display("FAIL arst_after cycle %0d: got valid=%b state=%0d want 0 IDLE",
                         c, out_valid, dbg_state);
            end
        end
        checks++;
        if (bad) failures++;
    endtask

    task automatic test_random_frames();
        logic [31:0] d;
        int          len;
        for (int f = 0; f < 40; f++) begin
            frame_q = {};
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                d = $urandom();
                case ($urandom_range(0, 2))
                    0: d = {{16{d[15]}}, d[15:0]};
                    1: d = {{4{d[31]}}, d[27:0]};
                    default: ;
                endcase
                frame_q.push_back(d);
            end
            run_frame($sformatf("rand%0d", f), 1'b1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_frame();
        test_saturation();
        test_count_sat();
        test_backpressure();
        test_clr();
        test_back_to_back();
        test_async_reset();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
